// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter onto one native
// valid/ready memory port, with registered slave-side requests.
//
// Ports:
//   clk, reset (sync, active-low)
//   m0_* / m1_* : master request (valid, instr, addr, wdata, wstrb),
//                 completion (ready pulse, rdata from a shared register)
//   s_*         : registered slave request, s_ready/s_rdata response
//   timeout     : one-cycle abort pulse alongside the aborted ready
//
// Build option: define MEM_ARB_TIMEOUT_EN to compile in the busy
// watchdog (TIMEOUT_CYCLES busy cycles without s_ready -> abort).
// Without it, timeout is tied 0 and BUSY waits indefinitely.

module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic        timeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_chk
    $error("mem_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        grant;
  logic        last_grant;
  logic        win;
  logic        req_any;
  logic        abort;
  logic [31:0] rdata;

  assign req_any  = m0_valid | m1_valid;
  assign m0_rdata = rdata;
  assign m1_rdata = rdata;

  // Winner: a tie goes to the master not granted last.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (m0_valid && m1_valid):  win = ~last_grant;
      (m1_valid && !m0_valid): win = 1'b1;
      default:                 win = 1'b0;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;

  // Counts stalled BUSY cycles; held at 0 outside BUSY so it is
  // clear on every entry to BUSY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state != BUSY) begin
      to_cnt <= '0;
    end else if (!s_ready) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  // Abort on the stalled cycle that brings the count to the limit;
  // a ready on that same cycle completes normally instead.
  assign abort = (state == BUSY) && !s_ready &&
                 (to_cnt == TO_LAST);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (s_ready || abort) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_valid    <= 1'b0;
      s_instr    <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      timeout    <= 1'b0;
      rdata      <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      timeout  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_any) begin
            s_valid <= 1'b1;
            grant   <= win;
            s_instr <= win ? m1_instr : m0_instr;
            s_addr  <= win ? m1_addr  : m0_addr;
            s_wdata <= win ? m1_wdata : m0_wdata;
            s_wstrb <= win ? m1_wstrb : m0_wstrb;
          end
        end
        BUSY: begin
          if (s_ready) begin
            rdata      <= s_rdata;
            s_valid    <= 1'b0;
            last_grant <= grant;
            m0_ready   <= ~grant;
            m1_ready   <= grant;
          end else if (abort) begin
            rdata      <= '0;
            s_valid    <= 1'b0;
            last_grant <= grant;
            m0_ready   <= ~grant;
            m1_ready   <= grant;
            timeout    <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;
  logic        m1_valid, m1_instr;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_valid (m0_valid),
    .m0_instr (m0_instr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_wstrb (m0_wstrb),
    .m0_ready (m0_ready),
    .m0_rdata (m0_rdata),
    .m1_valid (m1_valid),
    .m1_instr (m1_instr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_wstrb (m1_wstrb),
    .m1_ready (m1_ready),
    .m1_rdata (m1_rdata),
    .s_valid  (s_valid),
    .s_instr  (s_instr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .timeout  (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string tag,
                         input logic r0,
                         input logic r1,
                         input logic to);
    chk({tag, ".m0_ready"}, 32'(m0_ready), 32'(r0));
    chk({tag, ".m1_ready"}, 32'(m1_ready), 32'(r1));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".s_valid"}, 32'(s_valid), 32'd0);
    chk({tag, ".s_instr"}, 32'(s_instr), 32'd0);
    chk({tag, ".s_addr"}, s_addr, 32'd0);
    chk({tag, ".s_wdata"}, s_wdata, 32'd0);
    chk({tag, ".s_wstrb"}, 32'(s_wstrb), 32'd0);
    chk({tag, ".m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, ".m1_rdata"}, m1_rdata, 32'd0);
    chk_rdy(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    m0_valid = 1'b0; m0_instr = 1'b0;
    m0_addr  = '0;   m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0;
    m1_addr  = '0;   m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata  = '0;

    // reset state
    tick(); tick();
    chk_reset("rst");
    reset = 1'b1;
    tick();
    chk("idle.s_valid", 32'(s_valid), 32'd0);

    // single read, ready two cycles after s_valid
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    m0_instr = 1'b1;
    tick();
    chk("rd.s_valid", 32'(s_valid), 32'd1);
    chk("rd.s_addr", s_addr, 32'h100);
    chk("rd.s_instr", 32'(s_instr), 32'd1);
    chk_rdy("rd.c1", 1'b0, 1'b0, 1'b0);
    tick();
    chk("rd.c2.s_valid", 32'(s_valid), 32'd1);
    chk_rdy("rd.c2", 1'b0, 1'b0, 1'b0);
    tick();
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    chk("rd.c3.s_valid", 32'(s_valid), 32'd1);
    tick();
    s_ready = 1'b0; s_rdata = '0; m0_valid = 1'b0;
    chk_rdy("rd.done", 1'b1, 1'b0, 1'b0);
    chk("rd.m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd.done.s_valid", 32'(s_valid), 32'd0);
    tick();
    chk_rdy("rd.idle", 1'b0, 1'b0, 1'b0);
    m0_instr = 1'b0;

    // tie after reset: m0 first, then m1, 3 cycles apart
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h200;
    m1_valid = 1'b1; m1_addr = 32'h300;
    s_ready = 1'b1; s_rdata = 32'h11111111;
    tick();
    chk("tie.g0.s_addr", s_addr, 32'h200);
    tick();
    chk_rdy("tie.d0", 1'b1, 1'b0, 1'b0);
    chk("tie.d0.rdata", m0_rdata, 32'h11111111);
    m0_valid = 1'b0;
    s_rdata = 32'h22222222;
    tick();
    chk_rdy("tie.idle", 1'b0, 1'b0, 1'b0);
    chk("tie.idle.s_valid", 32'(s_valid), 32'd0);
    tick();
    chk("tie.g1.s_valid", 32'(s_valid), 32'd1);
    chk("tie.g1.s_addr", s_addr, 32'h300);
    tick();
    chk_rdy("tie.d1", 1'b0, 1'b1, 1'b0);
    chk("tie.d1.rdata", m1_rdata, 32'h22222222);
    m1_valid = 1'b0; s_ready = 1'b0;
    tick();

    // fairness: m0 continuous, m1 once
    m0_valid = 1'b1; m0_addr = 32'h400;
    tick();
    chk("fair.g0.s_addr", s_addr, 32'h400);
    m1_valid = 1'b1; m1_addr = 32'h500;
    s_ready = 1'b1; s_rdata = 32'h33333333;
    tick();
    chk_rdy("fair.d0", 1'b1, 1'b0, 1'b0);
    m0_addr = 32'h404;
    s_rdata = 32'h44444444;
    tick();
    tick();
    chk("fair.g1.s_addr", s_addr, 32'h500);
    tick();
    chk_rdy("fair.d1", 1'b0, 1'b1, 1'b0);
    m1_valid = 1'b0;
    s_rdata = 32'h55555555;
    tick();
    tick();
    chk("fair.g2.s_addr", s_addr, 32'h404);
    tick();
    chk_rdy("fair.d2", 1'b1, 1'b0, 1'b0);
    chk("fair.d2.rdata", m0_rdata, 32'h55555555);
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();

    // write passthrough from m1, fields stable in BUSY
    m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h600;
    m1_wdata = 32'h1234ABCD; m1_wstrb = 4'b0011;
    tick();
    m1_wdata = 32'hFFFFFFFF; m1_wstrb = 4'hF;
    m1_addr = 32'h6FC; m1_instr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wr.s_valid", 32'(s_valid), 32'd1);
      chk("wr.s_addr", s_addr, 32'h600);
      chk("wr.s_wdata", s_wdata, 32'h1234ABCD);
      chk("wr.s_wstrb", 32'(s_wstrb), 32'h3);
      chk("wr.s_instr", 32'(s_instr), 32'd0);
      tick();
    end
    s_ready = 1'b1; s_rdata = 32'h66666666;
    tick();
    chk_rdy("wr.done", 1'b0, 1'b1, 1'b0);
    m1_valid = 1'b0; m1_instr = 1'b0; s_ready = 1'b0;
    m1_wdata = '0; m1_wstrb = '0;
    tick();

    // m0 transaction so last_grant = 0 before reset
    m0_valid = 1'b1; m0_addr = 32'h680;
    s_ready = 1'b1; s_rdata = 32'h77777777;
    tick();
    tick();
    chk_rdy("pre.done", 1'b1, 1'b0, 1'b0);
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();

    // reset mid-BUSY
    m0_valid = 1'b1; m0_addr = 32'h700;
    m0_wdata = 32'hA5A5A5A5; m0_wstrb = 4'hF; m0_instr = 1'b1;
    tick();
    chk("rb.s_valid", 32'(s_valid), 32'd1);
    reset = 1'b0; s_ready = 1'b1; s_rdata = 32'h88888888;
    tick();
    chk_reset("rb");
    reset = 1'b1; m0_valid = 1'b0; s_ready = 1'b0;
    m0_instr = 1'b0; m0_wdata = '0; m0_wstrb = '0;
    tick();
    chk_rdy("rb.after", 1'b0, 1'b0, 1'b0);
    // last_grant back to 1: a tie goes to m0
    m0_valid = 1'b1; m0_addr = 32'hA00;
    m1_valid = 1'b1; m1_addr = 32'hB00;
    tick();
    chk("rb.tie.s_addr", s_addr, 32'hA00);
    s_ready = 1'b1; s_rdata = 32'h99999999;
    tick();
    chk_rdy("rb.d0", 1'b1, 1'b0, 1'b0);
    m0_valid = 1'b0; s_rdata = 32'h0BADF00D;
    tick();
    tick();
    chk("rb.g1.s_addr", s_addr, 32'hB00);
    tick();
    chk_rdy("rb.d1", 1'b0, 1'b1, 1'b0);
    chk("rb.d1.rdata", m1_rdata, 32'h0BADF00D);
    m1_valid = 1'b0; s_ready = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // slave never ready: abort after 4 stalled BUSY cycles
    m0_valid = 1'b1; m0_addr = 32'h800;
    s_rdata = 32'hCAFEF00D;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("to.busy.s_valid", 32'(s_valid), 32'd1);
      chk_rdy("to.busy", 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("to.c4.s_valid", 32'(s_valid), 32'd1);
    tick();
    chk_rdy("to.abort", 1'b1, 1'b0, 1'b1);
    chk("to.abort.rdata", m0_rdata, 32'd0);
    chk("to.abort.s_valid", 32'(s_valid), 32'd0);
    tick();
    chk_rdy("to.idle", 1'b0, 1'b0, 1'b0);
    // ready on exactly the 4th BUSY cycle wins
    m0_addr = 32'h804;
    tick();
    chk("to2.s_addr", s_addr, 32'h804);
    tick(); tick(); tick();
    s_ready = 1'b1; s_rdata = 32'h000055AA;
    tick();
    chk_rdy("to2.done", 1'b1, 1'b0, 1'b0);
    chk("to2.rdata", m0_rdata, 32'h000055AA);
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();
`else
    // no watchdog: a long stall keeps waiting
    m0_valid = 1'b1; m0_addr = 32'h800;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    chk("stall.s_valid", 32'(s_valid), 32'd1);
    chk_rdy("stall", 1'b0, 1'b0, 1'b0);
    s_ready = 1'b1; s_rdata = 32'h000055AA;
    tick();
    chk_rdy("stall.done", 1'b1, 1'b0, 1'b0);
    chk("stall.rdata", m0_rdata, 32'h000055AA);
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter for the core's native valid/ready memory bus: `mem_valid`, `mem_instr`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_ready`, `mem_rdata`. It sits between the `riscv` core (master 0) and a second master such as a debug or DMA port (master 1), and shares a single memory port between them. The arbiter serialises transactions with round-robin fairness and registers all slave-side request signals. An optional watchdog aborts a transaction that the slave never acknowledges.

## Interface
- `TIMEOUT_CYCLES`, default 255: busy cycles without `s_ready` before abort. Range 1..65535; only used when the timeout feature is compiled in.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `m0_valid`, `m1_valid`  in  1  request; held high until the matching `mN_ready` cycle.
- `m0_instr`, `m1_instr`  in  1  fetch tag.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte strobes; 0 means read.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  both driven from one shared read-data register; valid only with the own ready.
- `s_valid`, `s_instr`, `s_addr`, `s_wdata`, `s_wstrb`  out  1/1/32/32/4  registered slave request.
- `s_ready`  in  1  slave completion.
- `s_rdata`  in  32  slave read data, sampled with `s_ready`.
- `timeout`  out  1  one-cycle abort pulse, coincident with the aborted master's ready.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE**
  - If any `mN_valid` is high, choose a winner:
    - only one valid: grant it;
    - both valid: grant the master not granted last.
  - `last_grant` resets to 1, so master 0 wins the first tie.
  - At the edge, latch the winner's instr/addr/wdata/wstrb into the `s_*` registers, set `s_valid`, record `grant`, and go to BUSY.
- **BUSY**
  - `s_valid` stays 1 and the `s_*` fields stay stable.
  - On `s_ready`=1: capture `s_rdata` into the rdata register, clear `s_valid`, set `last_grant`=`grant`, and go to DONE.
  - Master inputs are ignored while in BUSY.
- **DONE**
  - `m<grant>_ready`=1 for exactly this cycle; the other master's ready stays 0. Then go to IDLE.
  - DONE gives the master one cycle to drop `valid`, which prevents a spurious re-grant.
- `s_ready` is ignored in IDLE and DONE.
- **Reset:** IDLE; `s_valid`=0; `s_instr`=0; `s_addr`=0; `s_wdata`=0; `s_wstrb`=0; `m0_ready`=`m1_ready`=0; rdata register=0; `timeout`=0; `last_grant`=1; timeout counter=0.
- **Reset mid-transaction:** the transaction is dropped silently and no ready is issued.

## Timing
- Request seen in IDLE at cycle 0 → `s_valid` high at cycle 1.
- `s_ready` at cycle k (k≥1) → `mN_ready` and `mN_rdata` valid at cycle k+1 → IDLE at k+2.
- **Minimum transaction:** 3 cycles, request to next possible grant.
- **Back-to-back requests from alternating masters:** one grant every 3 cycles when the slave responds immediately.
- `s_valid` falls on the edge after `s_ready`; the slave sees `s_valid` high for exactly the cycles up to and including its ready cycle.

## Configuration
- **With `MEM_ARB_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on entry to BUSY.
  - It increments each BUSY cycle with `s_ready`=0.
  - When the counter reaches `TIMEOUT_CYCLES`, the arbiter clears `s_valid`, loads rdata=0, and goes to DONE with `timeout`=1 alongside `m<grant>_ready`.
  - If `s_ready` arrives on the reaching cycle, normal completion wins and `timeout` stays 0.
  - `last_grant` updates on abort as on completion.
- **Without it:** no counter exists, `timeout` is tied 0, and BUSY waits indefinitely.

## Test plan
- **Single read:** m0 read at 0x100 with `s_ready` two cycles after `s_valid` and `s_rdata`=0xDEADBEEF → `m0_ready` pulses once, `m0_rdata`=0xDEADBEEF, `m1_ready` stays 0.
- **Tie after reset:** both masters valid on the first cycle → m0 granted first, m1 next. `s_addr` sequence matches, and requests are 3 cycles apart with immediate ready.
- **Fairness:** m0 requests continuously while m1 requests once → m1 is granted immediately after m0's current transaction, never starved.
- **Write passthrough:** m1 write with wstrb=4'b0011, wdata=0x1234ABCD → `s_wstrb`/`s_wdata`/`s_instr` match exactly and stay stable for the whole BUSY phase.
- **Reset mid-BUSY:** reset asserted while `s_valid`=1 → next cycle `s_valid`=0, all outputs at reset values, no ready pulse.
- **Timeout (with `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** slave never ready → `m0_ready`=1, `timeout`=1, `m0_rdata`=0. Then, with ready on exactly the 4th cycle, normal completion and `timeout`=0.
